// File: rtl/ccd_readout_sequencer.sv
// CCD readout sequencer: self-timed transfer gate, two-phase line shift
// clocks, pixel-valid flag/index and ADC frame strobe from internal counters.
module ccd_readout_sequencer #(
    parameter int ACTIVE_PIX  = 3648,
    parameter int DUMMY_PIX   = 5,
    parameter int TRAIL_PIX   = 14,
    parameter int HALF_PERIOD = 4,
    parameter int PHI_P_WIDTH = 8,
    parameter int GAP_CYC     = 4,
    parameter int PIX_W       = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_start,
    input  logic             i_continuous,
    output logic             o_phi_p,
    output logic             o_phi_l1,
    output logic             o_phi_l2,
    output logic             o_pixel_flag,
    output logic [PIX_W-1:0] o_pixel_idx,
    output logic             o_ADC_frame,
    output logic             o_busy,
    output logic             o_frame_done
);

    localparam int TOTAL  = DUMMY_PIX + ACTIVE_PIX + TRAIL_PIX;
    localparam int E_W    = $clog2(TOTAL + 1);
    localparam int HC_W   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int PC_MAX = (PHI_P_WIDTH > GAP_CYC) ? PHI_P_WIDTH : GAP_CYC;
    localparam int PC_W   = (PC_MAX > 1) ? $clog2(PC_MAX) : 1;

    localparam logic [E_W-1:0]  E_LO    = E_W'(DUMMY_PIX);
    localparam logic [E_W-1:0]  E_ACT   = E_W'(ACTIVE_PIX);
    localparam logic [E_W-1:0]  E_END   = E_W'(TOTAL);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);
    localparam logic [PC_W-1:0] P_LAST  = PC_W'(PHI_P_WIDTH - 1);
    localparam logic [PC_W-1:0] G_LAST  = PC_W'(GAP_CYC - 1);
    localparam logic            FLAG0   = (DUMMY_PIX == 0);

    if (ACTIVE_PIX < 1) begin : g_chk_active
        $error("ACTIVE_PIX must be >= 1");
    end
    if (DUMMY_PIX < 0 || TRAIL_PIX < 0) begin : g_chk_pad
        $error("DUMMY_PIX and TRAIL_PIX must be >= 0");
    end
    if (HALF_PERIOD < 1 || PHI_P_WIDTH < 1 || GAP_CYC < 1) begin : g_chk_time
        $error("HALF_PERIOD, PHI_P_WIDTH and GAP_CYC must be >= 1");
    end
    if ((2 ** PIX_W) < ACTIVE_PIX) begin : g_chk_pixw
        $error("PIX_W too narrow for ACTIVE_PIX");
    end

    typedef enum logic [1:0] {
        IDLE,
        TRANSFER,
        GAP,
        SHIFT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [HC_W-1:0] hc;
    logic            ph;
    logic [E_W-1:0]  e;
    logic            cont_q;

    logic             hc_wrap;
    logic [HC_W-1:0]  n_hc;
    logic             n_ph;
    logic [E_W-1:0]   n_e;
    logic [E_W-1:0]   n_off;
    logic             n_flag;
    logic [PIX_W-1:0] n_idx;
    logic             last;

    // Offset wraps to a large value below the dummy region, so one
    // unsigned compare covers both window bounds.
    always_comb begin
        hc_wrap = (hc == HC_LAST);
        n_hc    = hc_wrap ? '0 : hc + 1'b1;
        n_ph    = ph ^ hc_wrap;
        n_e     = (hc_wrap && !ph) ? e + 1'b1 : e;
        n_off   = n_e - E_LO;
        n_flag  = !n_ph && (n_off < E_ACT);
        n_idx   = n_flag ? PIX_W'(n_off) : '0;
        last    = ph && hc_wrap && (e == E_END);
    end

    assign o_ADC_frame = o_phi_p;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            pc           <= '0;
            hc           <= '0;
            ph           <= 1'b0;
            e            <= '0;
            cont_q       <= 1'b0;
            o_phi_p      <= 1'b0;
            o_phi_l1     <= 1'b1;
            o_phi_l2     <= 1'b0;
            o_pixel_flag <= 1'b0;
            o_pixel_idx  <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else if (!i_enable) begin
            state        <= IDLE;
            pc           <= '0;
            hc           <= '0;
            ph           <= 1'b0;
            e            <= '0;
            cont_q       <= 1'b0;
            o_phi_p      <= 1'b0;
            o_phi_l1     <= 1'b1;
            o_phi_l2     <= 1'b0;
            o_pixel_flag <= 1'b0;
            o_pixel_idx  <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // On the done cycle only the latched mode may restart.
                    if (o_frame_done ? cont_q : i_start) begin
                        state   <= TRANSFER;
                        pc      <= '0;
                        o_phi_p <= 1'b1;
                        o_busy  <= 1'b1;
                    end
                end
                TRANSFER: begin
                    if (pc == P_LAST) begin
                        state   <= GAP;
                        pc      <= '0;
                        o_phi_p <= 1'b0;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                GAP: begin
                    if (pc == G_LAST) begin
                        state        <= SHIFT;
                        pc           <= '0;
                        hc           <= '0;
                        ph           <= 1'b0;
                        e            <= '0;
                        o_pixel_flag <= FLAG0;
                        o_pixel_idx  <= '0;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        state        <= IDLE;
                        hc           <= '0;
                        ph           <= 1'b0;
                        e            <= '0;
                        cont_q       <= i_continuous;
                        o_phi_l1     <= 1'b1;
                        o_phi_l2     <= 1'b0;
                        o_pixel_flag <= 1'b0;
                        o_pixel_idx  <= '0;
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                    end else begin
                        hc           <= n_hc;
                        ph           <= n_ph;
                        e            <= n_e;
                        o_phi_l1     <= !n_ph;
                        o_phi_l2     <= n_ph;
                        o_pixel_flag <= n_flag;
                        o_pixel_idx  <= n_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ccd_readout_sequencer.md
Name: ccd_readout_sequencer

Overview:
- Self-timed, single-clock successor to the edge-driven analog signal generator.
- Generates the CCD transfer gate (phi_p) and the two-phase line shift clocks (phi_l1/phi_l2) itself.
- Derives a pixel-valid flag, pixel index and ADC frame strobe from its own counters.
- Sits between the SoC control registers and the CCD clock drivers/ADC front end; supports a programmable dummy/active/trailing pixel layout plus single-shot or continuous frame modes.

Parameters:
- ACTIVE_PIX, 3648, active pixels per line (>=1)
- DUMMY_PIX, 5, leading dummy pixels skipped before the first flagged pixel (>=0)
- TRAIL_PIX, 14, trailing pixels shifted out after the last active pixel (>=0)
- HALF_PERIOD, 4, i_clk cycles per phi_l half period (>=1)
- PHI_P_WIDTH, 8, i_clk cycles phi_p stays high (>=1)
- GAP_CYC, 4, i_clk cycles between phi_p fall and first shift half period (>=1)
- PIX_W, 12, width of o_pixel_idx (2**PIX_W >= ACTIVE_PIX)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  block enable; low forces synchronous abort to IDLE
- i_start  in  1  single-cycle frame start request
- i_continuous  in  1  1: restart a new frame automatically after each frame
- o_phi_p  out  1  transfer gate clock
- o_phi_l1  out  1  shift clock phase 1
- o_phi_l2  out  1  shift clock phase 2 (complement of phi_l1 during SHIFT)
- o_pixel_flag  out  1  high while phi_l1 is high for an active pixel
- o_pixel_idx  out  PIX_W  active pixel index 0..ACTIVE_PIX-1 while flag high, else 0
- o_ADC_frame  out  1  frame strobe, equal to o_phi_p
- o_busy  out  1  high in any state except IDLE
- o_frame_done  out  1  one-cycle pulse on normal frame completion

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, all counters 0, o_phi_l1=1, every other output 0.
- All outputs are registered. A state or counter change decided at edge t is visible at t+1.
- Idle levels (IDLE, TRANSFER, GAP): phi_l1=1, phi_l2=0, pixel_flag=0, pixel_idx=0.
- IDLE: if i_enable && i_start -> TRANSFER. i_start is ignored when i_enable=0 or when not in IDLE.
- TRANSFER: o_phi_p=o_ADC_frame=1 for exactly PHI_P_WIDTH cycles, then -> GAP.
- GAP: phi_p=0 for exactly GAP_CYC cycles, then -> SHIFT.
- SHIFT:
  - Half counter hc runs 0..HALF_PERIOD-1 and toggles phase bit ph on wrap.
  - ph=0: phi_l1=1, phi_l2=0. ph=1: phi_l1=0, phi_l2=1. SHIFT enters with ph=0, e=0.
  - Edge counter e increments at each phi_l2 rising transition (ph 0->1).
  - Pixel period = 2*HALF_PERIOD cycles.
- Flag window: o_pixel_flag = phi_l1 && DUMMY_PIX <= e <= DUMMY_PIX+ACTIVE_PIX-1. While flagged, o_pixel_idx = e-DUMMY_PIX.
- SHIFT length: TOTAL = DUMMY_PIX+ACTIVE_PIX+TRAIL_PIX pixel periods. SHIFT ends after the last phi_l2-high half period of period TOTAL.
- End of frame: on the cycle after the last SHIFT cycle, o_frame_done=1 for one cycle.
  - If i_continuous && i_enable: next state TRANSFER (phi_p high in that same cycle).
  - Otherwise: IDLE.
  - i_continuous is sampled only at frame end.
- Abort: i_enable=0 in any state -> next cycle IDLE with idle output levels and counters cleared; no o_frame_done. This applies mid-SHIFT and mid-TRANSFER.
- Simultaneity:
  - i_start with i_enable=0: no effect.
  - i_start on the frame_done cycle: ignored; only continuous mode restarts.
- Counter widths: e sized for TOTAL, hc for HALF_PERIOD, phase counter for max(PHI_P_WIDTH, GAP_CYC). No wrap occurs within a legal frame.
- Illegal parameter values are caught by elaboration-time checks; runtime behaviour for them is undefined.

Test Plan:
- Bench parameters for all scenarios: ACTIVE_PIX=4, DUMMY_PIX=5, TRAIL_PIX=2, HALF_PERIOD=2, PHI_P_WIDTH=3, GAP_CYC=2, PIX_W=3.
- Single shot: i_start at edge t ->
  - phi_p/ADC_frame high t+1..t+3; GAP t+4..t+5; SHIFT t+6..t+49 (11 periods of 4 cycles).
  - frame_done pulse at t+50, o_busy low from t+50.
- Pixel window (same frame): flag high at t+26..27 (idx0), t+30..31 (idx1), t+34..35 (idx2), t+38..39 (idx3).
  - No flag elsewhere; 8 flagged cycles total.
  - phi_l1 and phi_l2 never both high, never both low during SHIFT.
- Continuous: i_continuous=1, start at t -> frame_done at t+50 with phi_p high at t+51.
  - Second frame's flags offset by exactly 50 cycles from the first.
- Abort: drop i_enable at t+30 -> from t+31 state IDLE, phi_l1=1, phi_l2=0, flag=0, busy=0; no frame_done.
  - Re-enable plus start gives a clean full frame.
- Start ignored: pulse i_start at t+10 during SHIFT, and again with i_enable=0 while IDLE -> no extra phi_p, timing unchanged.
- Async reset: assert i_rst_n=0 mid-TRANSFER, between edges -> outputs go to reset values immediately, without waiting for an i_clk edge; release and start gives nominal timing.
